// File: rtl/stream_demux2_pkg.sv
// Shared route-select encodings and slot state for the 1:2 stream demux.
package stream_demux2_pkg;

    localparam logic SEL_CH1 = 1'b1;
    localparam logic SEL_CH2 = 1'b0;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry register slice for one demux channel; load-to-output latency 1 cycle.
// Accepts a new beat when empty or draining, so back-to-back beats stream at full rate.
module demux_slot
    import stream_demux2_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIN,
    output logic             VALID,
    input  logic             READY,
    output logic [WIDTH-1:0] DOUT,
    output logic             CAN_LOAD
);

    slot_state_t      state_q;
    slot_state_t      state_d;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload is left untouched on drain; consumers only look at it while VALID.
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_q <= '0;
        end else if (LOAD) begin
            data_q <= DIN;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SLOT_EMPTY: if (LOAD) state_d = SLOT_FULL;
            SLOT_FULL:  if (READY && !LOAD) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
    end

    always_comb begin
        VALID    = (state_q == SLOT_FULL);
        CAN_LOAD = (state_q == SLOT_EMPTY) || READY;
        DOUT     = data_q;
    end

endmodule

// File: rtl/stream_demux2.sv
// Registered 1:2 stream demux with per-channel slot and wrapping delivered-beat counter; 1 cycle latency.
// Input stalls only when the selected channel is full and not draining; the other channel keeps flowing.
module stream_demux2
    import stream_demux2_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     IN_DATA,
    input  logic                 IN_SEL,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic [WIDTH-1:0]     OUT_1_DATA,
    output logic                 OUT_1_VALID,
    input  logic                 OUT_1_READY,
    output logic [WIDTH-1:0]     OUT_2_DATA,
    output logic                 OUT_2_VALID,
    input  logic                 OUT_2_READY,
    output logic [CNT_WIDTH-1:0] CNT_1,
    output logic [CNT_WIDTH-1:0] CNT_2
);

    logic sel_ch1;
    logic sel_ch2;
    logic can_load_1;
    logic can_load_2;
    logic in_accept;
    logic load_1;
    logic load_2;

    assign sel_ch1   = (IN_SEL == SEL_CH1);
    assign sel_ch2   = (IN_SEL == SEL_CH2);
    assign IN_READY  = !RST && (sel_ch1 ? can_load_1 : can_load_2);
    assign in_accept = IN_VALID && IN_READY;
    assign load_1    = in_accept && sel_ch1;
    assign load_2    = in_accept && sel_ch2;

    demux_slot #(.WIDTH(WIDTH)) u_slot_1 (
        .CLK      (CLK),
        .RST      (RST),
        .LOAD     (load_1),
        .DIN      (IN_DATA),
        .VALID    (OUT_1_VALID),
        .READY    (OUT_1_READY),
        .DOUT     (OUT_1_DATA),
        .CAN_LOAD (can_load_1)
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot_2 (
        .CLK      (CLK),
        .RST      (RST),
        .LOAD     (load_2),
        .DIN      (IN_DATA),
        .VALID    (OUT_2_VALID),
        .READY    (OUT_2_READY),
        .DOUT     (OUT_2_DATA),
        .CAN_LOAD (can_load_2)
    );

    // Reset takes priority, so a drain coinciding with the reset edge is not counted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            CNT_1 <= '0;
            CNT_2 <= '0;
        end else begin
            if (OUT_1_VALID && OUT_1_READY) CNT_1 <= CNT_1 + CNT_WIDTH'(1);
            if (OUT_2_VALID && OUT_2_READY) CNT_2 <= CNT_2 + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_stream_demux2.sv
// Randomised and directed bench for stream_demux2 with a queue-based reference model and scoreboard.
module tb_stream_demux2;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic [W-1:0]  IN_DATA;
    logic          IN_SEL;
    logic          IN_VALID;
    logic          IN_READY;
    logic [W-1:0]  OUT_1_DATA;
    logic          OUT_1_VALID;
    logic          OUT_1_READY;
    logic [W-1:0]  OUT_2_DATA;
    logic          OUT_2_VALID;
    logic          OUT_2_READY;
    logic [CW-1:0] CNT_1;
    logic [CW-1:0] CNT_2;

    stream_demux2 #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .IN_DATA     (IN_DATA),
        .IN_SEL      (IN_SEL),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .OUT_1_DATA  (OUT_1_DATA),
        .OUT_1_VALID (OUT_1_VALID),
        .OUT_1_READY (OUT_1_READY),
        .OUT_2_DATA  (OUT_2_DATA),
        .OUT_2_VALID (OUT_2_VALID),
        .OUT_2_READY (OUT_2_READY),
        .CNT_1       (CNT_1),
        .CNT_2       (CNT_2)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel is a capacity-1 queue; sb_x lists beats still owed to the consumer.
    logic [W-1:0] mq1[$];
    logic [W-1:0] mq2[$];
    logic [W-1:0] sb1[$];
    logic [W-1:0] sb2[$];
    int  mcnt1 = 0;
    int  mcnt2 = 0;
    bit  acc = 1'b0;
    bit  started = 1'b0;

    function automatic bit model_ready();
        if (RST !== 1'b0) return 1'b0;
        if (IN_SEL) return (mq1.size() == 0) || OUT_1_READY;
        return (mq2.size() == 0) || OUT_2_READY;
    endfunction

    always @(posedge CLK) begin
        started = 1'b1;
        if (RST) begin
            mq1.delete(); mq2.delete(); sb1.delete(); sb2.delete();
            mcnt1 = 0; mcnt2 = 0; acc = 1'b0;
        end else begin
            acc = IN_VALID && model_ready();
            if (mq1.size() != 0 && OUT_1_READY) begin
                void'(mq1.pop_front());
                mcnt1 = (mcnt1 + 1) % (1 << CW);
            end
            if (mq2.size() != 0 && OUT_2_READY) begin
                void'(mq2.pop_front());
                mcnt2 = (mcnt2 + 1) % (1 << CW);
            end
            if (acc) begin
                if (IN_SEL) begin mq1.push_back(IN_DATA); sb1.push_back(IN_DATA); end
                else        begin mq2.push_back(IN_DATA); sb2.push_back(IN_DATA); end
            end
        end
    end

    // Monitor: compares DUT against the model away from the active edge and scores delivered beats.
    always @(negedge CLK) begin
        if (started) begin
            chk("in_ready", IN_READY, model_ready());
            chk("out1_valid", OUT_1_VALID, mq1.size() != 0);
            chk("out2_valid", OUT_2_VALID, mq2.size() != 0);
            chk("cnt1", CNT_1, mcnt1);
            chk("cnt2", CNT_2, mcnt2);
            if (OUT_1_VALID === 1'b1 && OUT_1_READY) begin
                if (sb1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out1_extra: got beat %0h expected none", OUT_1_DATA);
                end else chk("out1_data", OUT_1_DATA, sb1.pop_front());
            end
            if (OUT_2_VALID === 1'b1 && OUT_2_READY) begin
                if (sb2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out2_extra: got beat %0h expected none", OUT_2_DATA);
                end else chk("out2_data", OUT_2_DATA, sb2.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d, input logic s);
        bit done = 1'b0;
        IN_DATA = d; IN_SEL = s; IN_VALID = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            step();
            done = acc;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL send_timeout: beat %0h not accepted, expected acceptance within 50 cycles", d);
        end
        IN_VALID = 1'b0;
    endtask

    initial begin
        RST = 1'b1; IN_VALID = 1'b1; IN_SEL = 1'b1; IN_DATA = 8'h77;
        OUT_1_READY = 1'b1; OUT_2_READY = 1'b1;
        repeat (3) step();
        chk("rst_in_ready", IN_READY, 0);
        chk("rst_v1", OUT_1_VALID, 0);
        chk("rst_v2", OUT_2_VALID, 0);
        chk("rst_c1", CNT_1, 0);
        chk("rst_c2", CNT_2, 0);
        RST = 1'b0; IN_VALID = 1'b0;
        step();

        // Basic routing
        send(8'hA5, 1'b1);
        chk("basic_v1", OUT_1_VALID, 1);
        chk("basic_d1", OUT_1_DATA, 8'hA5);
        send(8'h3C, 1'b0);
        chk("basic_v2", OUT_2_VALID, 1);
        chk("basic_d2", OUT_2_DATA, 8'h3C);
        step(); step();
        chk("basic_c1", CNT_1, 1);
        chk("basic_c2", CNT_2, 1);

        // Back-pressure on channel 1, channel 2 unaffected
        OUT_1_READY = 1'b0;
        send(8'h11, 1'b1);
        step();
        chk("bp_hold_v", OUT_1_VALID, 1);
        chk("bp_hold_d", OUT_1_DATA, 8'h11);
        send(8'h55, 1'b0);
        chk("xblk_v2", OUT_2_VALID, 1);
        chk("xblk_d2", OUT_2_DATA, 8'h55);
        chk("xblk_d1", OUT_1_DATA, 8'h11);
        IN_DATA = 8'h22; IN_SEL = 1'b1; IN_VALID = 1'b1;
        #1 chk("bp_stall", IN_READY, 0);
        step();
        chk("bp_stall2", IN_READY, 0);
        chk("bp_still_d", OUT_1_DATA, 8'h11);
        OUT_1_READY = 1'b1;
        #1 chk("bp_release", IN_READY, 1);
        step();
        IN_VALID = 1'b0;
        chk("bp_swap_v", OUT_1_VALID, 1);
        chk("bp_swap_d", OUT_1_DATA, 8'h22);
        step();
        chk("bp_empty", OUT_1_VALID, 0);
        chk("bp_c1", CNT_1, 3);
        chk("bp_c2", CNT_2, 2);

        // Streaming with counter wrap
        RST = 1'b1; step(); RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            IN_VALID = 1'b1; IN_SEL = 1'b0; IN_DATA = W'(i);
            #1 chk("stream_rdy", IN_READY, 1);
            step();
        end
        IN_VALID = 1'b0;
        step(); step();
        chk("wrap_c2", CNT_2, 4);
        chk("wrap_c1", CNT_1, 0);

        // Reset while both slots hold beats
        OUT_1_READY = 1'b0; OUT_2_READY = 1'b0;
        send(8'hA1, 1'b1);
        send(8'hB2, 1'b0);
        chk("mid_v1_full", OUT_1_VALID, 1);
        chk("mid_v2_full", OUT_2_VALID, 1);
        RST = 1'b1; step(); RST = 1'b0;
        chk("mid_v1", OUT_1_VALID, 0);
        chk("mid_v2", OUT_2_VALID, 0);
        chk("mid_c1", CNT_1, 0);
        chk("mid_c2", CNT_2, 0);
        OUT_1_READY = 1'b1; OUT_2_READY = 1'b1;
        repeat (5) step();

        // Random traffic; producer holds its beat until accepted
        for (int n = 0; n < 800; n++) begin
            OUT_1_READY = ($urandom_range(0, 3) != 0);
            OUT_2_READY = ($urandom_range(0, 2) != 0);
            if (!IN_VALID || acc) begin
                IN_VALID = ($urandom_range(0, 3) != 0);
                IN_SEL   = $urandom_range(0, 1);
                IN_DATA  = W'($urandom);
            end
            step();
        end
        IN_VALID = 1'b0; OUT_1_READY = 1'b1; OUT_2_READY = 1'b1;
        repeat (5) step();
        chk("drain_sb1", sb1.size(), 0);
        chk("drain_sb2", sb2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
